sc_dmem_arbiter: RTL and testbench
==================================

Name: sc_dmem_arbiter

Overview:
Arbitrates the single data-memory port (dmem plus memory-mapped IO space) between the single-cycle CPU and a secondary bus master (program/data loader, debug or DMA engine).
- Sits between sc_cpu / ld master and sc_datamem.
- At most one access is granted per clock.
- CPU is stalled via cpu_stall (PC hold) when it loses arbitration.
- Loader bursts are bounded, and loader starvation is bounded.

Parameters:
- MAX_BURST, 4, max consecutive loader grants while cpu_req pending (range 1..15).
- STARVE_LIMIT, 8, cycles a loader request may wait before forced grant (range 1..255).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU requests dmem access this cycle (load/store).
- cpu_we  input  1  CPU write enable (wmem).
- cpu_addr  input  32  CPU address (aluout).
- cpu_wdata  input  32  CPU store data.
- cpu_rdata  output  32  read data to CPU (memout).
- cpu_stall  output  1  CPU not granted; hold PC and register writeback.
- ld_req  input  1  loader request, held until granted.
- ld_we  input  1  loader write enable.
- ld_addr  input  32  loader address.
- ld_wdata  input  32  loader write data.
- ld_gnt  output  1  loader access accepted this cycle.
- ld_rvalid  output  1  ld_rdata valid (one cycle after a read grant).
- ld_rdata  output  32  registered loader read data.
- mem_addr  output  32  to dmem.
- mem_wdata  output  32  to dmem.
- mem_we  output  1  to dmem.
- mem_rdata  input  32  from dmem, valid in the same clock cycle as mem_addr (mem_clk-driven).

Behaviour:
- Clocking/reset: one clock (clock); reset asynchronous active-low (resetn).
- While resetn=0:
  - state=ST_CPU; burst_cnt=0; wait_cnt=0.
  - ld_rvalid=0; ld_rdata=0.
  - ld_gnt=0, cpu_stall=0, mem_we=0 (gated by reset).
- Grant logic is combinational from state, burst_cnt, wait_cnt, cpu_req and ld_req; the state update is registered.
- ST_CPU (CPU priority):
  - ld_req & wait_cnt==STARVE_LIMIT -> grant LD; next ST_LD, burst_cnt=1.
  - else cpu_req -> grant CPU; stay.
  - else ld_req -> grant LD; next ST_LD, burst_cnt=1.
  - else no grant; stay.
- ST_LD (loader burst):
  - ld_req & (burst_cnt<MAX_BURST | ~cpu_req) -> grant LD; burst_cnt saturating increment at MAX_BURST.
  - else cpu_req -> grant CPU; next ST_CPU, burst_cnt=0.
  - else no grant; next ST_CPU, burst_cnt=0.
- wait_cnt:
  - increments each cycle ld_req=1 and not granted;
  - saturates at STARVE_LIMIT;
  - clears on ld grant or when ld_req=0.
- Datapath mux:
  - grant LD -> mem_addr/mem_wdata=ld_*, mem_we=ld_we.
  - otherwise -> mem_addr/mem_wdata=cpu_*, mem_we=cpu_we & cpu_req & grant_cpu.
  - mem_we is never 1 without a grant.
- cpu_rdata=mem_rdata, combinational; meaningful only when CPU is granted.
- cpu_stall=cpu_req & ~grant_cpu.
  - While stalled, the CPU holds cpu_req/addr/data stable; no side effects occur.
- ld_gnt=grant LD, combinational, same cycle.
  - The loader may change address/data/req on the next edge after ld_gnt.
- Loader read: on a grant with ld_we=0, the next edge registers ld_rdata=mem_rdata and sets ld_rvalid=1 for exactly one cycle. Loader writes never assert ld_rvalid.
- Back-to-back loader reads give a continuous ld_rvalid stream, one cycle delayed.
- Simultaneous requests:
  - decided by state rules above;
  - CPU wins in ST_CPU unless the starvation limit is reached.
- ld_req dropped mid-burst: burst ends; CPU is served the same cycle if requesting.
- Reset mid-burst: any pending ld_rvalid is lost; the loader must reissue.

Optional Feature:
Macro SC_DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_stall_cnt[15:0] (cycles with cpu_stall=1) and stat_ld_cnt[15:0] (loader grants).
  - Both are saturating at 16'hFFFF, cleared by resetn.
  - Adds input stat_clr: synchronous clear, takes priority over increment in the same cycle.
- Not defined: these ports and counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Reset with cpu_req=1, ld_req=1 held -> ld_gnt=0, cpu_stall=0, mem_we=0, ld_rvalid=0 while resetn=0. First cycle after release -> CPU granted (wait_cnt=0).
- cpu_req=1 continuous, ld_req=1 from cycle 0 -> CPU granted cycles 0..7; ld_gnt=1 at cycle 8 (STARVE_LIMIT=8); cpu_stall=1 that cycle.
- ld_req=1 only, 6 reads at addr 0x100..0x114 -> ld_gnt=1 each cycle; ld_rvalid=1 on cycles 1..6 with ld_rdata=mem contents. cpu_stall stays 0.
- In ST_LD, cpu_req asserted after 2 loader grants with ld_req held -> loader gets grants 3 and 4. Cycle after burst_cnt=4 -> CPU granted, state ST_CPU, ld_gnt=0.
- CPU store 0xDEADBEEF at 0x40 while loader writes 0x11 at 0x44 in the same cycle (ST_CPU, wait_cnt<8) -> mem_we pulse for CPU only. Next cycle loader write with mem_addr=0x44. Readback of 0x40 = 0xDEADBEEF and 0x44 = 0x11.
- With SC_DMEM_ARB_STATS_EN, run the starvation scenario for 20 cycles -> stat_ld_cnt and stat_stall_cnt match grant trace. stat_clr=1 -> both 0 next cycle. Force 65536 stall cycles -> stat_stall_cnt stays 0xFFFF.

Source files
------------

// File: rtl/sc_dmem_arbiter_if.sv
// sc_dmem_arbiter_if -- bus bundle for the data-memory arbiter.
// Groups the CPU port (cpu_*), the secondary loader port (ld_*) and the
// data-memory side (mem_*) into one interface.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants and mem_*)
//   master : environment view (CPU, loader and dmem models)
interface sc_dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/sc_dmem_arbiter.sv
// sc_dmem_arbiter -- shares the single data-memory port between the
// single-cycle CPU and a secondary bus master (loader / debug / DMA).
// At most one access is granted per clock. The CPU has priority and is
// stalled (cpu_stall) when it loses; loader bursts are capped at MAX_BURST
// while the CPU waits, and a waiting loader is force-granted after
// STARVE_LIMIT cycles.
//
// Ports:
//   clock, resetn : system clock (rising edge), async active-low reset
//   bus (slave)   : cpu_* request/stall/rdata, ld_* request/gnt/rvalid/rdata,
//                   mem_* towards dmem (mem_rdata valid in the same cycle)
//   Optional (macro SC_DMEM_ARB_STATS_EN):
//     stat_clr       : synchronous clear of both counters (wins over increment)
//     stat_stall_cnt : saturating count of cpu_stall cycles
//     stat_ld_cnt    : saturating count of loader grants
//
// Parameters: MAX_BURST (1..15), STARVE_LIMIT (1..255).
module sc_dmem_arbiter #(
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clock,
  input  logic resetn,
  sc_dmem_arbiter_if.slave bus
`ifdef SC_DMEM_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_stall_cnt,
  output logic [15:0] stat_ld_cnt
`endif
);

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_LD  = 1'b1
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic [7:0] WAIT_MAX  = 8'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  burst_cnt;
  logic [7:0]  wait_cnt;
  logic        grant_ld;
  logic        grant_cpu;
  logic        ld_rvalid_q;
  logic [31:0] ld_rdata_q;

  // Grants are combinational so the winner uses the port in the same cycle.
  // Nothing is granted while reset is asserted.
  always_comb begin
    grant_ld  = 1'b0;
    grant_cpu = 1'b0;
    if (resetn) begin
      case (state)
        ST_CPU: begin
          if (bus.ld_req && wait_cnt == WAIT_MAX) grant_ld  = 1'b1;
          else if (bus.cpu_req)                   grant_cpu = 1'b1;
          else if (bus.ld_req)                    grant_ld  = 1'b1;
        end
        ST_LD: begin
          // Burst continues past the cap only while the CPU is idle.
          if (bus.ld_req && (burst_cnt < BURST_MAX || !bus.cpu_req)) grant_ld  = 1'b1;
          else if (bus.cpu_req)                                      grant_cpu = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ld_gnt    = grant_ld;
  assign bus.cpu_stall = resetn & bus.cpu_req & ~grant_cpu;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.mem_addr  = grant_ld ? bus.ld_addr  : bus.cpu_addr;
  assign bus.mem_wdata = grant_ld ? bus.ld_wdata : bus.cpu_wdata;
  assign bus.mem_we    = grant_ld ? bus.ld_we    : (bus.cpu_we & bus.cpu_req & grant_cpu);
  assign bus.ld_rvalid = ld_rvalid_q;
  assign bus.ld_rdata  = ld_rdata_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_CPU;
      burst_cnt   <= '0;
      wait_cnt    <= '0;
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      if (grant_ld) begin
        state <= ST_LD;
        if (state != ST_LD)           burst_cnt <= 4'd1;
        else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        state     <= ST_CPU;
        burst_cnt <= '0;
      end

      if (grant_ld || !bus.ld_req)   wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 8'd1;

      ld_rvalid_q <= grant_ld & ~bus.ld_we;
      if (grant_ld && !bus.ld_we) ld_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef SC_DMEM_ARB_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_stall_cnt <= '0;
      stat_ld_cnt    <= '0;
    end else if (stat_clr) begin
      stat_stall_cnt <= '0;
      stat_ld_cnt    <= '0;
    end else begin
      if (bus.cpu_stall && stat_stall_cnt != '1) stat_stall_cnt <= stat_stall_cnt + 16'd1;
      if (grant_ld && stat_ld_cnt != '1)         stat_ld_cnt    <= stat_ld_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// tb_sc_dmem_arbiter -- self-checking bench for sc_dmem_arbiter.
// A behavioural dmem array sits on the mem_* side; a reference model of the
// arbitration rules (integer counters, shadow memory) predicts grants, mux
// selection and loader read data. Scenario tasks run in sequence, followed
// by a randomized run compared cycle by cycle against the model.
module tb_sc_dmem_arbiter;
  localparam int unsigned MAX_BURST    = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  sc_dmem_arbiter_if bus();

`ifdef SC_DMEM_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_stall_cnt;
  logic [15:0] stat_ld_cnt;
`endif

  sc_dmem_arbiter #(
    .MAX_BURST   (MAX_BURST),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
`ifdef SC_DMEM_ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_stall_cnt(stat_stall_cnt),
    .stat_ld_cnt   (stat_ld_cnt)
`endif
  );

  // Data memory: combinational read, write on the clock edge.
  logic [31:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clock) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_ld_owner;
  int unsigned m_burst;
  int unsigned m_wait;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [256];
  bit          exp_ld, exp_cpu, exp_stall, exp_we;
  logic [31:0] exp_addr, exp_wdata;

  task automatic model_reset;
    m_ld_owner = 0; m_burst = 0; m_wait = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic model_eval;
    exp_ld = 0; exp_cpu = 0;
    if (resetn) begin
      if (!m_ld_owner) begin
        if (bus.ld_req && m_wait >= STARVE_LIMIT) exp_ld = 1;
        else if (bus.cpu_req)                     exp_cpu = 1;
        else if (bus.ld_req)                      exp_ld = 1;
      end else begin
        if (bus.ld_req && (m_burst < MAX_BURST || !bus.cpu_req)) exp_ld = 1;
        else if (bus.cpu_req)                                    exp_cpu = 1;
      end
    end
    exp_stall = resetn && bus.cpu_req && !exp_cpu;
    exp_we    = exp_ld ? bus.ld_we : (exp_cpu && bus.cpu_we);
    exp_addr  = exp_ld ? bus.ld_addr : bus.cpu_addr;
    exp_wdata = exp_ld ? bus.ld_wdata : bus.cpu_wdata;
  endtask

  // Advance one clock and carry the model across the same edge.
  task automatic tick;
    model_eval;
    if (!resetn) model_reset;
    else begin
      m_rvalid = exp_ld && !bus.ld_we;
      if (m_rvalid) m_rdata = ref_mem[bus.ld_addr[9:2]];
      if (exp_ld && bus.ld_we)   ref_mem[bus.ld_addr[9:2]]  = bus.ld_wdata;
      if (exp_cpu && bus.cpu_we) ref_mem[bus.cpu_addr[9:2]] = bus.cpu_wdata;
      if (exp_ld) begin
        m_burst    = m_ld_owner ? ((m_burst < MAX_BURST) ? m_burst + 1 : m_burst) : 1;
        m_ld_owner = 1;
      end else begin
        m_ld_owner = 0;
        m_burst    = 0;
      end
      if (exp_ld || !bus.ld_req) m_wait = 0;
      else if (m_wait < STARVE_LIMIT) m_wait = m_wait + 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cpu(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = data;
  endtask

  task automatic drive_ld(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] data);
    bus.ld_req = req; bus.ld_we = we; bus.ld_addr = addr; bus.ld_wdata = data;
  endtask

  task automatic apply_reset;
    drive_cpu(0, 0, '0, '0);
    drive_ld(0, 0, '0, '0);
`ifdef SC_DMEM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    resetn = 1'b0;
    model_reset;
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    model_reset;
    drive_cpu(1, 1, 32'h10, 32'hAAAA_5555);
    drive_ld(1, 1, 32'h20, 32'h1234_5678);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks += 4;
      if (bus.ld_gnt !== 1'b0)    begin errors++; $display("FAIL rst_ld_gnt c%0d: got %b want 0", c, bus.ld_gnt); end
      if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall c%0d: got %b want 0", c, bus.cpu_stall); end
      if (bus.mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we c%0d: got %b want 0", c, bus.mem_we); end
      if (bus.ld_rvalid !== 1'b0) begin errors++; $display("FAIL rst_ld_rvalid c%0d: got %b want 0", c, bus.ld_rvalid); end
      @(posedge clock);
    end
    #1;
    resetn = 1'b1;
    #1;
    checks += 3;
    if (bus.ld_gnt !== 1'b0)       begin errors++; $display("FAIL rel_ld_gnt: got %b want 0", bus.ld_gnt); end
    if (bus.cpu_stall !== 1'b0)    begin errors++; $display("FAIL rel_cpu_stall: got %b want 0", bus.cpu_stall); end
    if (bus.mem_addr !== 32'h10)   begin errors++; $display("FAIL rel_mem_addr: got %h want 00000010", bus.mem_addr); end
    tick;
  endtask

  // Fill memory through the loader so the shadow memory is fully known.
  task automatic init_mem;
    drive_cpu(0, 0, '0, '0);
    for (int i = 0; i < 256; i++) begin
      drive_ld(1, 1, 32'(i * 4), $urandom);
      #1;
      tick;
    end
    drive_ld(0, 0, '0, '0);
    #1;
    tick;
  endtask

  task automatic test_starvation;
    logic [31:0] a;
    apply_reset;
    a = 32'h0000_0300;
    drive_cpu(1, 0, a, '0);
    drive_ld(1, 0, 32'h80, '0);
    for (int c = 0; c < 14; c++) begin
      #1;
      checks += 2;
      if (bus.ld_gnt !== (c >= 8 && c <= 11))
        begin errors++; $display("FAIL starve_ld_gnt c%0d: got %b want %b", c, bus.ld_gnt, (c >= 8 && c <= 11)); end
      if (bus.cpu_stall !== (c >= 8 && c <= 11))
        begin errors++; $display("FAIL starve_cpu_stall c%0d: got %b want %b", c, bus.cpu_stall, (c >= 8 && c <= 11)); end
      if (c == 0) begin
        checks++;
        if (bus.cpu_rdata !== ref_mem[a[9:2]])
          begin errors++; $display("FAIL starve_cpu_rdata: got %h want %h", bus.cpu_rdata, ref_mem[a[9:2]]); end
      end
      tick;
    end
  endtask

  task automatic test_ld_reads;
    apply_reset;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive_ld(1, 0, 32'h100 + 32'(4 * i), '0);
      else       drive_ld(0, 0, '0, '0);
      #1;
      if (i < 6) begin
        checks += 2;
        if (bus.ld_gnt !== 1'b1)    begin errors++; $display("FAIL rd_ld_gnt i%0d: got %b want 1", i, bus.ld_gnt); end
        if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_cpu_stall i%0d: got %b want 0", i, bus.cpu_stall); end
      end
      checks++;
      if (bus.ld_rvalid !== (i >= 1 && i <= 6))
        begin errors++; $display("FAIL rd_rvalid i%0d: got %b want %b", i, bus.ld_rvalid, (i >= 1 && i <= 6)); end
      if (i >= 1 && i <= 6) begin
        checks++;
        if (bus.ld_rdata !== ref_mem[64 + i - 1])
          begin errors++; $display("FAIL rd_rdata i%0d: got %h want %h", i, bus.ld_rdata, ref_mem[64 + i - 1]); end
      end
      tick;
    end
  endtask

  task automatic test_burst_limit;
    logic [5:0] want_gnt;
    logic [5:0] want_stall;
    want_gnt   = 6'b001111;
    want_stall = 6'b001100;
    apply_reset;
    for (int c = 0; c < 6; c++) begin
      drive_ld(1, 0, 32'h200 + 32'(4 * c), '0);
      drive_cpu(c >= 2, 0, 32'h300, '0);
      #1;
      checks += 2;
      if (bus.ld_gnt !== want_gnt[c])
        begin errors++; $display("FAIL burst_ld_gnt c%0d: got %b want %b", c, bus.ld_gnt, want_gnt[c]); end
      if (bus.cpu_stall !== want_stall[c])
        begin errors++; $display("FAIL burst_cpu_stall c%0d: got %b want %b", c, bus.cpu_stall, want_stall[c]); end
      tick;
    end
  endtask

  task automatic test_same_cycle_write;
    apply_reset;
    drive_cpu(1, 1, 32'h40, 32'hDEAD_BEEF);
    drive_ld(1, 1, 32'h44, 32'h11);
    #1;
    checks += 4;
    if (bus.mem_we !== 1'b1)             begin errors++; $display("FAIL sw_cpu_we: got %b want 1", bus.mem_we); end
    if (bus.mem_addr !== 32'h40)         begin errors++; $display("FAIL sw_cpu_addr: got %h want 00000040", bus.mem_addr); end
    if (bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_cpu_wdata: got %h want deadbeef", bus.mem_wdata); end
    if (bus.ld_gnt !== 1'b0)             begin errors++; $display("FAIL sw_ld_gnt0: got %b want 0", bus.ld_gnt); end
    tick;
    drive_cpu(0, 0, '0, '0);
    #1;
    checks += 3;
    if (bus.ld_gnt !== 1'b1)     begin errors++; $display("FAIL sw_ld_gnt1: got %b want 1", bus.ld_gnt); end
    if (bus.mem_addr !== 32'h44) begin errors++; $display("FAIL sw_ld_addr: got %h want 00000044", bus.mem_addr); end
    if (bus.mem_we !== 1'b1)     begin errors++; $display("FAIL sw_ld_we: got %b want 1", bus.mem_we); end
    tick;
    drive_ld(1, 0, 32'h40, '0);
    #1;
    tick;
    drive_ld(1, 0, 32'h44, '0);
    #1;
    checks++;
    if (bus.ld_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_rb40: got %h want deadbeef", bus.ld_rdata); end
    tick;
    drive_ld(0, 0, '0, '0);
    #1;
    checks++;
    if (bus.ld_rdata !== 32'h11) begin errors++; $display("FAIL sw_rb44: got %h want 00000011", bus.ld_rdata); end
    tick;
  endtask

  task automatic test_random;
    bit last_gnt, last_stall;
    apply_reset;
    last_gnt = 0; last_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 399) == 0) begin resetn = 1'b0; model_reset; end
      if (!bus.ld_req || last_gnt)
        drive_ld($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
      if (!last_stall)
        drive_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
      #1;
      model_eval;
      checks += 6;
      if (bus.ld_gnt !== exp_ld)       begin errors++; $display("FAIL rnd_ld_gnt c%0d: got %b want %b", c, bus.ld_gnt, exp_ld); end
      if (bus.cpu_stall !== exp_stall) begin errors++; $display("FAIL rnd_cpu_stall c%0d: got %b want %b", c, bus.cpu_stall, exp_stall); end
      if (bus.mem_we !== exp_we)       begin errors++; $display("FAIL rnd_mem_we c%0d: got %b want %b", c, bus.mem_we, exp_we); end
      if (bus.mem_addr !== exp_addr)   begin errors++; $display("FAIL rnd_mem_addr c%0d: got %h want %h", c, bus.mem_addr, exp_addr); end
      if (bus.ld_rvalid !== m_rvalid)  begin errors++; $display("FAIL rnd_ld_rvalid c%0d: got %b want %b", c, bus.ld_rvalid, m_rvalid); end
      if (bus.ld_rdata !== m_rdata)    begin errors++; $display("FAIL rnd_ld_rdata c%0d: got %h want %h", c, bus.ld_rdata, m_rdata); end
      if (exp_we) begin
        checks++;
        if (bus.mem_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_mem_wdata c%0d: got %h want %h", c, bus.mem_wdata, exp_wdata); end
      end
      if (exp_cpu && !bus.cpu_we) begin
        checks++;
        if (bus.cpu_rdata !== ref_mem[bus.cpu_addr[9:2]])
          begin errors++; $display("FAIL rnd_cpu_rdata c%0d: got %h want %h", c, bus.cpu_rdata, ref_mem[bus.cpu_addr[9:2]]); end
      end
      last_gnt   = exp_ld;
      last_stall = exp_stall;
      tick;
    end
    resetn = 1'b1;
  endtask

`ifdef SC_DMEM_ARB_STATS_EN
  task automatic test_stats;
    int unsigned n_stall, n_ld;
    apply_reset;
    n_stall = 0; n_ld = 0;
    drive_cpu(1, 0, 32'h300, '0);
    drive_ld(1, 0, 32'h80, '0);
    for (int c = 0; c < 20; c++) begin
      #1;
      model_eval;
      if (exp_stall) n_stall++;
      if (exp_ld)    n_ld++;
      tick;
    end
    checks += 2;
    if (stat_stall_cnt !== 16'(n_stall)) begin errors++; $display("FAIL stat_stall: got %0d want %0d", stat_stall_cnt, n_stall); end
    if (stat_ld_cnt !== 16'(n_ld))       begin errors++; $display("FAIL stat_ld: got %0d want %0d", stat_ld_cnt, n_ld); end
    stat_clr = 1'b1;
    #1;
    tick;
    stat_clr = 1'b0;
    checks += 2;
    if (stat_stall_cnt !== 16'd0) begin errors++; $display("FAIL stat_clr_stall: got %0d want 0", stat_stall_cnt); end
    if (stat_ld_cnt !== 16'd0)    begin errors++; $display("FAIL stat_clr_ld: got %0d want 0", stat_ld_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    init_mem;
    test_starvation;
    test_ld_reads;
    test_burst_limit;
    test_same_cycle_write;
    test_random;
`ifdef SC_DMEM_ARB_STATS_EN
    test_stats;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
